// File: rtl/mips_fetch_pkg.sv
// -----------------------------------------------------------------------------
// mips_fetch_pkg
//   Shared definitions for the MIPS instruction-fetch front end.
//   - REDIR_* : encodings of the redir_mode input (11 is reserved and is
//               handled like JR by the fetch unit).
//   - RESET_PC_DEFAULT : default first fetch address after reset.
//   - fetch_entry_t    : one instruction-queue entry {inst, pc}.
// -----------------------------------------------------------------------------
package mips_fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;

  localparam logic [1:0] REDIR_J  = 2'b00;
  localparam logic [1:0] REDIR_BR = 2'b01;
  localparam logic [1:0] REDIR_JR = 2'b10;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//   DEPTH-entry synchronous FIFO of fetch_entry_t (64 bits) with flush.
//   Ports:
//     i_clk, i_rst_n  : clock, asynchronous active-low reset
//     i_push, i_push_data : write one entry (ignored when full)
//     i_pop           : consume the head entry (ignored when empty)
//     i_flush         : empty the queue; wins over push and pop
//     o_head          : head entry (storage is not reset; qualify with o_empty)
//     o_count         : number of valid entries (0..DEPTH)
//     o_full, o_empty : occupancy flags
//   DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module fetch_queue
  import mips_fetch_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_push,
  input  fetch_entry_t  i_push_data,
  input  logic          i_pop,
  input  logic          i_flush,
  output fetch_entry_t  o_head,
  output logic [CW-1:0] o_count,
  output logic          o_full,
  output logic          o_empty
);

  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic w_do_push;
  logic w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Control: pointers and occupancy.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Data: storage array, no reset needed since o_empty qualifies the head.
  always_ff @(posedge i_clk) begin
    if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_push_data;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction-fetch front end: owns the fetch PC, issues word reads to a
//   1-cycle-latency instruction memory, buffers responses in fetch_queue and
//   presents {inst, pc, pc+4} to decode over valid/ready. Handles J/JAL,
//   taken-branch and JR redirects by flushing, and halts on a zero word.
//   Ports:
//     clock, reset_n            : clock, asynchronous active-low reset
//     imem_req, imem_addr       : read request and word-aligned byte address
//     imem_rdata                : read data, valid the cycle after imem_req
//     redirect, redir_mode      : redirect pulse and kind (J / BR / JR)
//     redir_pc4, redir_imm,
//     redir_reg                 : operands for the redirect target
//     out_valid, out_ready      : decode handshake
//     out_inst, out_pc,
//     out_pc_plus4              : head instruction, its address, address+4
//     halted                    : sticky, a zero word reached the queue head
// -----------------------------------------------------------------------------
module fetch_unit
  import mips_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [1:0]  redir_mode,
  input  logic [31:0] redir_pc4,
  input  logic [25:0] redir_imm,
  input  logic [31:0] redir_reg,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus4,
  output logic        halted
);

  localparam int CW = $clog2(DEPTH) + 1;

  // Redirect target, all arithmetic modulo 2^32. Mode 11 falls into the
  // JR arm; JR drops the two low register bits.
  function automatic logic [31:0] calc_target(
    input logic [1:0]  mode,
    input logic [31:0] pc4,
    input logic [25:0] imm,
    input logic [29:0] reg_hi
  );
    logic [31:0] br_off;
    br_off = {{14{imm[15]}}, imm[15:0], 2'b00};
    case (mode)
      REDIR_J:  return {pc4[31:28], imm, 2'b00};
      REDIR_BR: return pc4 + br_off;
      REDIR_JR: return {reg_hi, 2'b00};
      default:  return {reg_hi, 2'b00};
    endcase
  endfunction

  logic [31:0] r_fetch_pc;
  logic        r_epoch;
  logic        r_inflight;
  logic        r_inflight_epoch;
  logic [31:0] r_inflight_pc;
  logic        r_halted;

  fetch_entry_t  w_head;
  fetch_entry_t  w_push_entry;
  logic [CW-1:0] w_count;
  logic [CW-1:0] w_occ;
  logic          w_full;
  logic          w_empty;
  logic          w_redir;
  logic          w_req;
  logic          w_resp_ok;
  logic          w_push;
  logic          w_pop;
  logic          w_head_zero;
  logic [31:0]   w_target;
  logic          w_unused_reg_lsbs;

  assign w_unused_reg_lsbs = ^redir_reg[1:0];

  // Once halted, redirects have no effect at all.
  assign w_redir  = redirect && !r_halted;
  assign w_target = calc_target(redir_mode, redir_pc4, redir_imm, redir_reg[31:2]);

  // Slots already committed = buffered entries + the response still due.
  assign w_occ = w_count + CW'(r_inflight);
  // reset_n gates the request so it reads 0 while reset is held.
  assign w_req = reset_n && !r_halted && !redirect && !w_full && (w_occ < CW'(DEPTH));

  assign imem_req  = w_req;
  assign imem_addr = r_fetch_pc;

  // A response belongs to the current stream only if its epoch still matches.
  assign w_resp_ok    = r_inflight && (r_inflight_epoch == r_epoch) && !r_halted;
  assign w_push       = w_resp_ok && !w_redir;
  assign w_push_entry = '{inst: imem_rdata, pc: r_inflight_pc};

  // A zero word at the head is never presented; it triggers halt instead.
  assign w_head_zero = !w_empty && (w_head.inst == 32'h0);
  assign out_valid   = !w_empty && !w_head_zero && !r_halted;
  assign w_pop       = out_valid && out_ready;

  assign out_inst     = w_empty ? 32'h0 : w_head.inst;
  assign out_pc       = w_empty ? 32'h0 : w_head.pc;
  assign out_pc_plus4 = out_pc + 32'd4;
  assign halted       = r_halted;

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .i_clk       (clock),
    .i_rst_n     (reset_n),
    .i_push      (w_push),
    .i_push_data (w_push_entry),
    .i_pop       (w_pop),
    .i_flush     (w_redir),
    .o_head      (w_head),
    .o_count     (w_count),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  // Request stage -> response stage: control state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_fetch_pc       <= RESET_PC;
      r_epoch          <= 1'b0;
      r_inflight       <= 1'b0;
      r_inflight_epoch <= 1'b0;
      r_halted         <= 1'b0;
    end else begin
      r_inflight <= w_req;
      if (w_req) r_inflight_epoch <= r_epoch;
      if (w_redir) begin
        r_fetch_pc <= w_target;
        r_epoch    <= ~r_epoch;
      end else if (w_req) begin
        r_fetch_pc <= r_fetch_pc + 32'd4;
      end
      if (w_head_zero) r_halted <= 1'b1;
    end
  end

  // Request stage -> response stage: address travelling with the request.
  always_ff @(posedge clock) begin
    if (w_req) r_inflight_pc <= r_fetch_pc;
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam logic [31:0] RPC   = 32'h0040_0000;
  localparam int          DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'h0;
  logic        redirect = 1'b0;
  logic [1:0]  redir_mode = 2'b00;
  logic [31:0] redir_pc4 = 32'h0;
  logic [25:0] redir_imm = 26'h0;
  logic [31:0] redir_reg = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;
  logic        halted;

  int n_checks = 0;
  int n_fail   = 0;

  logic        zero_en = 1'b0;
  logic [31:0] zero_addr = 32'h0;

  fetch_unit #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .redirect     (redirect),
    .redir_mode   (redir_mode),
    .redir_pc4    (redir_pc4),
    .redir_imm    (redir_imm),
    .redir_reg    (redir_reg),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_inst     (out_inst),
    .out_pc       (out_pc),
    .out_pc_plus4 (out_pc_plus4),
    .halted       (halted)
  );

  always #5 clock = ~clock;

  // Memory contents: address-derived nonzero words, optionally one zero word.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    if (zero_en && a == zero_addr) return 32'h0;
    return (a ^ 32'h5A5A_0000) | 32'h1;
  endfunction

  always @(posedge clock) imem_rdata <= imem_req ? word_at(imem_addr) : 32'hDEAD_BEEF;

  function automatic logic [31:0] model_target(input logic [1:0] m, input logic [31:0] pc4,
                                               input logic [25:0] imm, input logic [31:0] rv);
    int off;
    case (m)
      2'd0:    return (pc4 & 32'hF000_0000) | (32'(imm) * 32'd4);
      2'd1: begin
        off = int'($signed(imm[15:0]));
        return pc4 + 32'(off * 4);
      end
      default: return rv - (rv % 32'd4);
    endcase
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    @(negedge clock);
  endtask

  task automatic do_reset();
    step();
    reset_n = 1'b0;
    redirect = 1'b0;
    out_ready = 1'b0;
    repeat (2) step();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    step();
    reset_n = 1'b0;
    step();
    settle();
    n_checks++;
    if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", imem_req); end
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    n_checks++;
    if (out_inst !== 32'h0 || out_pc !== 32'h0) begin
      n_fail++; $display("FAIL reset_outs: inst=%h pc=%h expected 0/0", out_inst, out_pc);
    end
    n_checks++;
    if (out_pc_plus4 !== 32'h4) begin n_fail++; $display("FAIL reset_pc4: got %h expected 4", out_pc_plus4); end
    n_checks++;
    if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b expected 0", halted); end
  endtask

  task automatic test_stream();
    logic [31:0] e;
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      settle();
      n_checks++;
      if (imem_req !== 1'b1 || imem_addr !== RPC + 32'(4 * k)) begin
        n_fail++; $display("FAIL stream_req k=%0d: req=%b addr=%h expected 1/%h", k, imem_req, imem_addr, RPC + 32'(4 * k));
      end
      n_checks++;
      if (k < 2) begin
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_early_valid k=%0d: got %b expected 0", k, out_valid); end
      end else begin
        e = RPC + 32'(4 * (k - 2));
        if (out_valid !== 1'b1 || out_pc !== e || out_inst !== word_at(e) || out_pc_plus4 !== e + 32'd4) begin
          n_fail++; $display("FAIL stream_out k=%0d: v=%b pc=%h inst=%h pc4=%h expected 1/%h/%h/%h",
                             k, out_valid, out_pc, out_inst, out_pc_plus4, e, word_at(e), e + 32'd4);
        end
      end
      step();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int nreq;
    int ndel;
    do_reset();
    out_ready = 1'b0;
    nreq = 0;
    for (int k = 0; k < 10; k++) begin
      settle();
      if (imem_req === 1'b1) nreq++;
      if (k >= 5) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_pc !== RPC || out_inst !== word_at(RPC)) begin
          n_fail++; $display("FAIL bp_hold k=%0d: v=%b pc=%h inst=%h expected 1/%h/%h", k, out_valid, out_pc, out_inst, RPC, word_at(RPC));
        end
      end
      step();
    end
    settle();
    n_checks++;
    if (nreq != DEPTH) begin n_fail++; $display("FAIL bp_nreq: got %0d expected %0d", nreq, DEPTH); end
    n_checks++;
    if (imem_req !== 1'b0) begin n_fail++; $display("FAIL bp_req_full: got %b expected 0", imem_req); end
    step();
    out_ready = 1'b1;
    ndel = 0;
    for (int c = 0; c < 30 && ndel < 8; c++) begin
      settle();
      if (out_valid === 1'b1) begin
        n_checks++;
        if (out_pc !== RPC + 32'(4 * ndel)) begin
          n_fail++; $display("FAIL bp_order i=%0d: got %h expected %h", ndel, out_pc, RPC + 32'(4 * ndel));
        end
        ndel++;
      end
      step();
    end
    n_checks++;
    if (ndel != 8) begin n_fail++; $display("FAIL bp_count: got %0d expected 8", ndel); end
    out_ready = 1'b0;
  endtask

  task automatic test_redirect(input string name, input logic [1:0] mode, input logic [31:0] pc4,
                               input logic [25:0] imm, input logic [31:0] rv, input logic [31:0] exp_t);
    do_reset();
    out_ready = 1'b1;
    repeat (4) step();
    redirect = 1'b1; redir_mode = mode; redir_pc4 = pc4; redir_imm = imm; redir_reg = rv;
    settle();
    n_checks++;
    if (out_valid !== 1'b1 || out_pc !== RPC + 32'd8 || imem_req !== 1'b0) begin
      n_fail++; $display("FAIL %s_redir_cycle: v=%b pc=%h req=%b expected 1/%h/0", name, out_valid, out_pc, imem_req, RPC + 32'd8);
    end
    step();
    redirect = 1'b0;
    redir_pc4 = $urandom(); redir_imm = 26'($urandom()); redir_reg = $urandom();
    settle();
    n_checks++;
    if (out_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== exp_t) begin
      n_fail++; $display("FAIL %s_after: v=%b req=%b addr=%h expected 0/1/%h", name, out_valid, imem_req, imem_addr, exp_t);
    end
    step();
    settle();
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL %s_stale: v=%b pc=%h expected valid 0", name, out_valid, out_pc); end
    step();
    settle();
    n_checks++;
    if (out_valid !== 1'b1 || out_pc !== exp_t || out_inst !== word_at(exp_t) || imem_addr !== exp_t + 32'd8) begin
      n_fail++; $display("FAIL %s_target: v=%b pc=%h inst=%h addr=%h expected 1/%h/%h/%h",
                         name, out_valid, out_pc, out_inst, imem_addr, exp_t, word_at(exp_t), exp_t + 32'd8);
    end
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_halt();
    zero_en = 1'b1;
    zero_addr = RPC + 32'hC;
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      settle();
      n_checks++;
      if (k >= 2 && k <= 4) begin
        if (out_valid !== 1'b1 || out_pc !== RPC + 32'(4 * (k - 2))) begin
          n_fail++; $display("FAIL halt_deliver k=%0d: v=%b pc=%h expected 1/%h", k, out_valid, out_pc, RPC + 32'(4 * (k - 2)));
        end
      end else if (k >= 5) begin
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL halt_valid k=%0d: got %b expected 0", k, out_valid); end
      end else begin
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL halt_early k=%0d: got %b expected 0", k, out_valid); end
      end
      n_checks++;
      if (halted !== (k >= 6)) begin n_fail++; $display("FAIL halt_flag k=%0d: got %b expected %b", k, halted, k >= 6); end
      if (k >= 6) begin
        n_checks++;
        if (imem_req !== 1'b0) begin n_fail++; $display("FAIL halt_req k=%0d: got %b expected 0", k, imem_req); end
      end
      step();
      redirect = (k == 7);
      redir_mode = 2'b00; redir_pc4 = RPC; redir_imm = 26'h0000100;
    end
    redirect = 1'b0;
    zero_en = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b0;
    repeat (8) step();
    settle();
    n_checks++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_pre: valid=%b expected 1", out_valid); end
    step();
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (imem_req !== 1'b0 || out_valid !== 1'b0 || halted !== 1'b0) begin
      n_fail++; $display("FAIL rmid_ctl: req=%b v=%b halted=%b expected 0/0/0", imem_req, out_valid, halted);
    end
    n_checks++;
    if (out_pc !== 32'h0 || out_inst !== 32'h0 || out_pc_plus4 !== 32'h4) begin
      n_fail++; $display("FAIL rmid_data: pc=%h inst=%h pc4=%h expected 0/0/4", out_pc, out_inst, out_pc_plus4);
    end
    step();
    reset_n = 1'b1;
    out_ready = 1'b1;
    settle();
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== RPC) begin
      n_fail++; $display("FAIL rmid_restart: req=%b addr=%h expected 1/%h", imem_req, imem_addr, RPC);
    end
    step();
    settle();
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_flushed: v=%b pc=%h expected valid 0", out_valid, out_pc); end
    step();
    settle();
    n_checks++;
    if (out_valid !== 1'b1 || out_pc !== RPC) begin
      n_fail++; $display("FAIL rmid_first: v=%b pc=%h expected 1/%h", out_valid, out_pc, RPC);
    end
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] exp_fetch, exp_pc, tgt, prev_pc, prev_inst;
    logic        prev_redir, prev_stall;
    int          ndel;
    do_reset();
    exp_fetch = RPC; exp_pc = RPC;
    prev_redir = 1'b0; prev_stall = 1'b0; prev_pc = 32'h0; prev_inst = 32'h0;
    ndel = 0;
    for (int c = 0; c < 400; c++) begin
      out_ready  = ($urandom_range(0, 3) != 0);
      redirect   = ($urandom_range(0, 9) == 0);
      redir_mode = 2'($urandom_range(0, 3));
      redir_pc4  = $urandom() & ~32'h3;
      redir_imm  = 26'($urandom());
      redir_reg  = $urandom();
      tgt = model_target(redir_mode, redir_pc4, redir_imm, redir_reg);
      settle();
      if (redirect) begin
        n_checks++;
        if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rnd_req_redir c=%0d: got %b expected 0", c, imem_req); end
      end else if (prev_redir) begin
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== exp_fetch) begin
          n_fail++; $display("FAIL rnd_target_req c=%0d: req=%b addr=%h expected 1/%h", c, imem_req, imem_addr, exp_fetch);
        end
      end else if (imem_req === 1'b1) begin
        n_checks++;
        if (imem_addr !== exp_fetch) begin n_fail++; $display("FAIL rnd_addr c=%0d: got %h expected %h", c, imem_addr, exp_fetch); end
      end
      if (prev_redir) begin
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_flush c=%0d: valid=%b expected 0", c, out_valid); end
      end else if (prev_stall) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_pc !== prev_pc || out_inst !== prev_inst) begin
          n_fail++; $display("FAIL rnd_stable c=%0d: v=%b pc=%h inst=%h expected 1/%h/%h", c, out_valid, out_pc, out_inst, prev_pc, prev_inst);
        end
      end
      if (out_valid === 1'b1 && out_ready) begin
        n_checks++;
        if (out_pc !== exp_pc || out_inst !== word_at(exp_pc) || out_pc_plus4 !== exp_pc + 32'd4) begin
          n_fail++; $display("FAIL rnd_deliver c=%0d: pc=%h inst=%h pc4=%h expected %h/%h/%h",
                             c, out_pc, out_inst, out_pc_plus4, exp_pc, word_at(exp_pc), exp_pc + 32'd4);
        end
        exp_pc = exp_pc + 32'd4;
        ndel++;
      end
      prev_stall = (out_valid === 1'b1) && !out_ready && !redirect;
      prev_pc    = out_pc;
      prev_inst  = out_inst;
      prev_redir = redirect;
      if (redirect) begin
        exp_fetch = tgt;
        exp_pc    = tgt;
      end else if (imem_req === 1'b1) begin
        exp_fetch = exp_fetch + 32'd4;
      end
      step();
    end
    redirect = 1'b0;
    n_checks++;
    if (ndel < 50) begin n_fail++; $display("FAIL rnd_progress: delivered %0d expected at least 50", ndel); end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "time limit expired");
  end

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect("jump",   2'b00, 32'h0040_000C, 26'h0100010, 32'h0,          32'h0040_0040);
    test_redirect("branch", 2'b01, 32'h0040_0010, 26'h000FFFC, 32'h0,          32'h0040_0000);
    test_redirect("jr",     2'b10, 32'h0,         26'h0,       32'h0040_0023,  32'h0040_0020);
    test_redirect("rsvd",   2'b11, 32'h0,         26'h0,       32'h0040_0107,  32'h0040_0104);
    test_halt();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
